octree_fetch: RTL

OCTREE_FETCH -- requirements
Module: octree_fetch

---
 rtl/octree_fetch_pkg.sv | 26 ++
 rtl/octree_fetch_node_decode.sv | 45 ++++
 rtl/octree_fetch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/octree_fetch_pkg.sv
// Shared types and constants for the octree fetch walker.
// Holds the node header layout, the walker FSM state encoding and the
// fixed field positions used by the header decoder.
package octree_pkg;

    localparam int LEAF_BIT    = 31;
    localparam int MASK_WIDTH  = 8;
    localparam int BASE_WIDTH  = 23;
    localparam int COLOR_WIDTH = 24;

    // Node header word: leaf flag, child-valid mask, child base address
    typedef struct packed {
        logic                  leaf;
        logic [MASK_WIDTH-1:0] mask;
        logic [BASE_WIDTH-1:0] base;
    } node_hdr_t;

    // Walker states; the top exposes the encoding on dbg_state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/octree_fetch_node_decode.sv
// Combinational node header decoder.
// Splits a header word into leaf / mask / base, picks the child index
// {z,y,x} from the coordinate bit selected by the current depth and
// forms the child header address base + 2*index at 23-bit width.
module octree_node_decode
    import octree_pkg::*;
#(
    parameter int COORD_WIDTH = 4,
    parameter int DEPTH_WIDTH = $clog2(COORD_WIDTH + 1)
) (
    input  logic [31:0]            header,
    input  logic [COORD_WIDTH-1:0] cx,
    input  logic [COORD_WIDTH-1:0] cy,
    input  logic [COORD_WIDTH-1:0] cz,
    input  logic [DEPTH_WIDTH-1:0] depth,
    output logic                   leaf,
    output logic                   child_valid,
    output logic [BASE_WIDTH-1:0]  child_addr
);

    node_hdr_t hdr;
    logic [2:0] child_idx;
    logic       depth_ok;

    assign hdr  = node_hdr_t'(header);
    assign leaf = hdr.leaf;

    // Select the coordinate bit for this level; level 0 uses the MSB.
    // At depth == COORD_WIDTH there is no bit left, so the index stays 0
    // and child_valid is forced low.
    always_comb begin
        child_idx = 3'd0;
        depth_ok  = 1'b0;
        for (int b = 0; b < COORD_WIDTH; b++) begin
            if (int'(depth) == COORD_WIDTH - 1 - b) begin
                child_idx = {cz[b], cy[b], cx[b]};
                depth_ok  = 1'b1;
            end
        end
    end

    assign child_valid = depth_ok & hdr.mask[child_idx];
    assign child_addr  = hdr.base + {{(BASE_WIDTH-4){1'b0}}, child_idx, 1'b0};

endmodule

// File: rtl/octree_fetch.sv
// Octree voxel lookup walker.
// Accepts one (x,y,z) query, walks the octree stored in a synchronous ROM
// from ROOT_ADDR down, and returns leaf colour / miss / error with the
// termination depth. Each level costs one FETCH and one EVAL cycle.
// Optional feature macro: OCTREE_FETCH_STATS_EN enables the per-query
// ROM fetch counter on r_fetches; without it r_fetches is tied to 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. q_ready is high only in IDLE; r_valid is high only in
// DONE and every r_* output is held constant until r_ready is seen.
module octree_fetch
    import octree_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter int          COORD_WIDTH   = 4,
    parameter int          ROM_DEPTH     = 38,
    parameter int unsigned ROOT_ADDR     = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               q_valid,
    output logic                               q_ready,
    input  logic [COORD_WIDTH-1:0]             q_x,
    input  logic [COORD_WIDTH-1:0]             q_y,
    input  logic [COORD_WIDTH-1:0]             q_z,
    output logic [ADDRESS_WIDTH-1:0]           addr1,
    output logic [ADDRESS_WIDTH-1:0]           addr2,
    output logic                               ren,
    input  logic [DATA_WIDTH-1:0]              dout1,
    input  logic [DATA_WIDTH-1:0]              dout2,
    output logic                               r_valid,
    input  logic                               r_ready,
    output logic                               r_hit,
    output logic                               r_err,
    output logic [COLOR_WIDTH-1:0]             r_color,
    output logic [$clog2(COORD_WIDTH+1)-1:0]   r_depth,
    output logic [7:0]                         r_fetches,
    output logic [1:0]                         dbg_state
);

    localparam int DEPW = $clog2(COORD_WIDTH + 1);
    localparam logic [ADDRESS_WIDTH:0] ROM_LIMIT = (ADDRESS_WIDTH+1)'(ROM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] ROOT_HDR = ADDRESS_WIDTH'(ROOT_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] ROOT_PAY = ADDRESS_WIDTH'(ROOT_ADDR + 1);

    fetch_state_e               state_q;
    logic                       q_ready_q;
    logic                       ren_q;
    logic [ADDRESS_WIDTH-1:0]   addr1_q;
    logic [ADDRESS_WIDTH-1:0]   addr2_q;
    logic [COORD_WIDTH-1:0]     x_q;
    logic [COORD_WIDTH-1:0]     y_q;
    logic [COORD_WIDTH-1:0]     z_q;
    logic [DEPW-1:0]            depth_q;
    logic                       r_valid_q;
    logic                       r_hit_q;
    logic                       r_err_q;
    logic [COLOR_WIDTH-1:0]     r_color_q;

    logic                       hdr_leaf;
    logic                       hdr_child_valid;
    logic [BASE_WIDTH-1:0]      hdr_child_addr;
    logic [ADDRESS_WIDTH-1:0]   child_addr_ext;
    logic [ADDRESS_WIDTH:0]     child_pay_wide;
    logic                       child_oor;
    logic                       accept;
    logic                       unused_payload_hi;

    octree_node_decode #(
        .COORD_WIDTH (COORD_WIDTH),
        .DEPTH_WIDTH (DEPW)
    ) u_decode (
        .header      (dout1[31:0]),
        .cx          (x_q),
        .cy          (y_q),
        .cz          (z_q),
        .depth       (depth_q),
        .leaf        (hdr_leaf),
        .child_valid (hdr_child_valid),
        .child_addr  (hdr_child_addr)
    );

    // The payload address of the child is checked one bit wider than the
    // address bus so base near the top of the address space cannot wrap.
    assign child_addr_ext    = ADDRESS_WIDTH'(hdr_child_addr);
    assign child_pay_wide    = {1'b0, child_addr_ext} + {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    assign child_oor         = (child_pay_wide >= ROM_LIMIT);
    assign accept            = (state_q == IDLE) && q_valid && q_ready_q;
    assign unused_payload_hi = ^dout2[DATA_WIDTH-1:COLOR_WIDTH];

    // Walker FSM: all outputs are registered and change with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            q_ready_q <= 1'b0;
            ren_q     <= 1'b0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            depth_q   <= '0;
            r_valid_q <= 1'b0;
            r_hit_q   <= 1'b0;
            r_err_q   <= 1'b0;
            r_color_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q       <= q_x;
                        y_q       <= q_y;
                        z_q       <= q_z;
                        depth_q   <= '0;
                        addr1_q   <= ROOT_HDR;
                        addr2_q   <= ROOT_PAY;
                        ren_q     <= 1'b1;
                        q_ready_q <= 1'b0;
                        r_hit_q   <= 1'b0;
                        r_err_q   <= 1'b0;
                        r_color_q <= '0;
                        state_q   <= FETCH;
                    end else begin
                        q_ready_q <= 1'b1;
                    end
                end
                FETCH: begin
                    ren_q   <= 1'b0;
                    state_q <= EVAL;
                end
                EVAL: begin
                    if (hdr_leaf) begin
                        r_hit_q   <= 1'b1;
                        r_color_q <= dout2[COLOR_WIDTH-1:0];
                        r_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (depth_q == DEPW'(COORD_WIDTH)) begin
                        r_err_q   <= 1'b1;
                        r_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (!hdr_child_valid) begin
                        r_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (child_oor) begin
                        r_err_q   <= 1'b1;
                        r_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        addr1_q   <= child_addr_ext;
                        addr2_q   <= child_pay_wide[ADDRESS_WIDTH-1:0];
                        depth_q   <= depth_q + DEPW'(1);
                        ren_q     <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                DONE: begin
                    if (r_ready) begin
                        r_valid_q <= 1'b0;
                        q_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef OCTREE_FETCH_STATS_EN
    logic [7:0] fetch_cnt_q;

    // Count FETCH cycles of the current query, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 8'd0;
        end else if (accept) begin
            fetch_cnt_q <= 8'd0;
        end else if (state_q == FETCH && fetch_cnt_q != 8'hFF) begin
            fetch_cnt_q <= fetch_cnt_q + 8'd1;
        end
    end

    assign r_fetches = fetch_cnt_q;
`else
    assign r_fetches = 8'd0;
`endif

    assign q_ready   = q_ready_q;
    assign ren       = ren_q;
    assign addr1     = addr1_q;
    assign addr2     = addr2_q;
    assign r_valid   = r_valid_q;
    assign r_hit     = r_hit_q;
    assign r_err     = r_err_q;
    assign r_color   = r_color_q;
    assign r_depth   = depth_q;
    assign dbg_state = state_q;

endmodule
